fir_mac_serial: RTL

FIR_MAC_SERIAL -- requirements
Module: fir_mac_serial

---
 rtl/fir_mac_serial.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_serial.sv
// Serial-MAC FIR filter: one coefficient product per enabled cycle, one result per sample.
// A single product register sits between the tap multiplier and the accumulator.
module fir_mac_serial #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 8,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [4:0]               coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     busy
);

   localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int IDX_W  = $clog2(TAPS + 1);
   localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]               state_q, state_d;
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [DATA_W-1:0] x_d [TAPS];
   logic signed [COEF_W-1:0] c_q [TAPS];
   logic signed [COEF_W-1:0] c_d [TAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [PROD_W-1:0] prod_p0_q, prod_p0_d;
   logic                     vld_p0_q, vld_p0_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]  out_data_q, out_data_d;

   logic signed [PROD_W-1:0] prod_sel;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_sum;
   logic                     addr_ok;

   function automatic logic signed [PROD_W-1:0] mul_tap(
      input logic signed [COEF_W-1:0] c,
      input logic signed [DATA_W-1:0] x
   );
      logic signed [PROD_W-1:0] cw;
      logic signed [PROD_W-1:0] xw;
      cw = {{DATA_W{c[COEF_W-1]}}, c};
      xw = {{COEF_W{x[DATA_W-1]}}, x};
      return cw * xw;
   endfunction

   // Arithmetic shift, then clamp into the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] hi;
      logic signed [EXT_W-1:0] lo;
      sh  = acc >>> SHIFT;
      ext = {{(EXT_W-ACC_W){sh[ACC_W-1]}}, sh};
      hi  = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      lo  = ~hi;
      if (ext > hi) begin
         return hi[OUT_W-1:0];
      end else if (ext < lo) begin
         return lo[OUT_W-1:0];
      end else begin
         return ext[OUT_W-1:0];
      end
   endfunction

   assign in_ready  = (state_q == S_IDLE) && ena;
   assign busy      = (state_q == S_MAC) || (state_q == S_OUT);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign addr_ok   = int'(coef_addr) < TAPS;

   always_comb begin
      prod_sel = '0;
      for (int i = 0; i < TAPS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            prod_sel = mul_tap(c_q[i], x_q[i]);
         end
      end
   end

   // Stage p0 -> accumulator: fold in the product registered on the previous cycle.
   always_comb begin
      prod_ext = {{(ACC_W-PROD_W){prod_p0_q[PROD_W-1]}}, prod_p0_q};
      acc_sum  = vld_p0_q ? (acc_q + prod_ext) : acc_q;
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      c_d         = c_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      prod_p0_d   = prod_p0_q;
      vld_p0_d    = vld_p0_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (ena) begin
         if (coef_we && (state_q == S_IDLE) && addr_ok) begin
            for (int i = 0; i < TAPS; i++) begin
               if (coef_addr == 5'(i)) begin
                  c_d[i] = coef_data;
               end
            end
         end
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_d[0] = in_data;
                  for (int k = 1; k < TAPS; k++) begin
                     x_d[k] = x_q[k-1];
                  end
                  acc_d    = '0;
                  idx_d    = '0;
                  vld_p0_d = 1'b0;
                  state_d  = S_MAC;
               end
            end
            S_MAC: begin
               acc_d = acc_sum;
               if (idx_q < IDX_W'(TAPS)) begin
                  prod_p0_d = prod_sel;
                  vld_p0_d  = 1'b1;
                  idx_d     = idx_q + IDX_W'(1);
               end else begin
                  // Last product has drained into acc_sum; publish the result.
                  vld_p0_d    = 1'b0;
                  out_data_d  = sat_out(acc_sum);
                  out_valid_d = 1'b1;
                  state_d     = S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
         acc_q       <= '0;
         idx_q       <= '0;
         prod_p0_q   <= '0;
         vld_p0_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         c_q         <= c_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         prod_p0_q   <= prod_p0_d;
         vld_p0_q    <= vld_p0_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule
